// File: rtl/prog_delay_line_if.sv
`default_nettype none
// ============================================================================
//  Module      : prog_delay_line_if
//  Description : Control, input-sample and output-sample bundle for the
//                programmable delay line. The master drives controls and the
//                input stream; the slave (the delay line) returns the delayed
//                stream and its status.
//  Revision    : 1.0 - initial release
// ============================================================================
interface prog_delay_line_if #(
   parameter int MAX_DEPTH = 16,
   parameter int DIM       = 16,
   parameter int NCH       = 1
) ();
   localparam int DW = $clog2(MAX_DEPTH + 1);

   logic                 stall;
   logic                 flush;
   logic                 cfg_load;
   logic [DW-1:0]        cfg_delay;
   logic                 in_valid;
   logic [NCH*DIM-1:0]   in_data;
   logic                 out_valid;
   logic [NCH*DIM-1:0]   out_data;
   logic [DW-1:0]        cur_delay;
   logic                 primed;

   modport master (
      output stall, flush, cfg_load, cfg_delay, in_valid, in_data,
      input  out_valid, out_data, cur_delay, primed
   );

   modport slave (
      input  stall, flush, cfg_load, cfg_delay, in_valid, in_data,
      output out_valid, out_data, cur_delay, primed
   );
endinterface
`default_nettype wire

// File: rtl/prog_delay_line.sv
`default_nettype none
// ============================================================================
//  Module      : prog_delay_line
//  Description : Runtime-programmable delay line, 0..MAX_DEPTH cycles, for NCH
//                lanes of DIM-bit data plus a travelling valid bit. A fill
//                counter reports when the pipeline has refilled after a
//                flush or a delay change.
//  Revision    : 1.0 - initial release
// ============================================================================
module prog_delay_line #(
   parameter int MAX_DEPTH = 16,
   parameter int DIM       = 16,
   parameter int NCH       = 1,
   parameter int RST_DELAY = 0
) (
   input  wire logic          clk,
   input  wire logic          clr_n,
   prog_delay_line_if.slave   bus
);
   localparam int DW = $clog2(MAX_DEPTH + 1);
   localparam int SW = NCH*DIM + 1;   // {valid, data}

   localparam logic [DW-1:0] c_max_delay = DW'(MAX_DEPTH);
   localparam logic [DW-1:0] c_rst_delay = DW'(RST_DELAY);

   logic [SW-1:0] r_stage [1:MAX_DEPTH];
   logic [DW-1:0] r_cur_delay;
   logic [DW-1:0] r_fill;
   logic [DW-1:0] w_sat_delay;
   logic [SW-1:0] w_out;
   logic          w_clear;

   // Requested delay clamped to the physical depth; a load or flush empties the pipe
   always_comb begin
      w_sat_delay = (bus.cfg_delay > c_max_delay) ? c_max_delay : bus.cfg_delay;
      w_clear     = bus.cfg_load | bus.flush;
   end

   // Stage shift register: clear on load/flush (even when stalled), hold on stall
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         for (int i = 1; i <= MAX_DEPTH; i++) r_stage[i] <= '0;
      end else if (w_clear) begin
         for (int i = 1; i <= MAX_DEPTH; i++) r_stage[i] <= '0;
      end else if (!bus.stall) begin
         r_stage[1] <= {bus.in_valid, bus.in_data};
         for (int i = 2; i <= MAX_DEPTH; i++) r_stage[i] <= r_stage[i-1];
      end
   end

   // Active delay setting and fill counter (saturates at the active delay)
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         r_cur_delay <= c_rst_delay;
         r_fill      <= '0;
      end else if (bus.cfg_load) begin
         r_cur_delay <= w_sat_delay;
         r_fill      <= '0;
      end else if (bus.flush) begin
         r_fill      <= '0;
      end else if (!bus.stall && (r_fill != r_cur_delay)) begin
         r_fill      <= r_fill + 1'b1;
      end
   end

   // Output tap: zero delay is a straight wire, otherwise select stage d
   always_comb begin
      w_out = '0;
      if (r_cur_delay == '0) begin
         w_out = {bus.in_valid, bus.in_data};
      end else begin
         for (int i = 1; i <= MAX_DEPTH; i++) begin
            if (r_cur_delay == DW'(i)) w_out = r_stage[i];
         end
      end
   end

   assign bus.out_valid = w_out[SW-1];
   assign bus.out_data  = w_out[SW-2:0];
   assign bus.cur_delay = r_cur_delay;
   assign bus.primed    = (r_fill == r_cur_delay);

endmodule
`default_nettype wire

// File: tb/tb_prog_delay_line.sv
`default_nettype none
// ============================================================================
//  Module      : tb_prog_delay_line
//  Description : Directed self-checking bench for prog_delay_line
//                (MAX_DEPTH=16, DIM=16, NCH=2, RST_DELAY=3).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_prog_delay_line;
   localparam int MAX_DEPTH = 16;
   localparam int DIM       = 16;
   localparam int NCH       = 2;
   localparam int RST_DELAY = 3;

   logic clk;
   logic clr_n;
   int   n_total = 0;
   int   n_fail  = 0;

   prog_delay_line_if #(.MAX_DEPTH(MAX_DEPTH), .DIM(DIM), .NCH(NCH)) bus ();

   prog_delay_line #(
      .MAX_DEPTH (MAX_DEPTH),
      .DIM       (DIM),
      .NCH       (NCH),
      .RST_DELAY (RST_DELAY)
   ) dut (
      .clk   (clk),
      .clr_n (clr_n),
      .bus   (bus)
   );

   // 10 ns clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, observed running expected finished");
      $fatal(1, "watchdog expired");
   end

   // Sample pattern: lane0 = k, lane1 = k + 0x100
   function automatic logic [31:0] mk(input int k);
      mk = {16'(k + 256), 16'(k)};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic ev, input logic [31:0] ed,
                          input logic ep, input logic [4:0] ecd);
      chk({tag, "_valid"},  64'(bus.out_valid), 64'(ev));
      chk({tag, "_data"},   64'(bus.out_data),  64'(ed));
      chk({tag, "_primed"}, 64'(bus.primed),    64'(ep));
      chk({tag, "_delay"},  64'(bus.cur_delay), 64'(ecd));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic feed(input int k);
      bus.in_valid = 1'b1;
      bus.in_data  = mk(k);
      tick();
   endtask

   task automatic load(input logic [4:0] d);
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.cfg_load  = 1'b1;
      bus.cfg_delay = d;
      tick();
      bus.cfg_load  = 1'b0;
   endtask

   initial begin
      clr_n         = 1'b0;
      bus.stall     = 1'b0;
      bus.flush     = 1'b0;
      bus.cfg_load  = 1'b0;
      bus.cfg_delay = '0;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;

      // ---- Reset state
      #12;
      chk_out("reset", 1'b0, 32'h0, 1'b0, 5'd3);
      clr_n = 1'b1;
      #1;
      chk_out("post_release", 1'b0, 32'h0, 1'b0, 5'd3);

      // ---- Delay 3 stream, 1..8 valid back to back
      for (int k = 1; k <= 8; k++) begin
         feed(k);
         if (k >= 3) chk_out($sformatf("d3_k%0d", k), 1'b1, mk(k-2), 1'b1, 5'd3);
         else        chk_out($sformatf("d3_k%0d", k), 1'b0, 32'h0,   1'b0, 5'd3);
      end
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      tick(); chk_out("d3_drain7", 1'b1, mk(7), 1'b1, 5'd3);
      tick(); chk_out("d3_drain8", 1'b1, mk(8), 1'b1, 5'd3);
      tick(); chk_out("d3_bubble", 1'b0, 32'h0, 1'b1, 5'd3);

      // ---- Delay 4 with a 2-cycle stall mid-stream
      load(5'd4);
      chk_out("d4_load", 1'b0, 32'h0, 1'b0, 5'd4);
      for (int k = 1; k <= 6; k++) feed(k);
      chk_out("d4_pre_stall", 1'b1, mk(3), 1'b1, 5'd4);
      bus.stall = 1'b1;
      feed(99);
      chk_out("d4_stall1", 1'b1, mk(3), 1'b1, 5'd4);
      feed(98);
      chk_out("d4_stall2", 1'b1, mk(3), 1'b1, 5'd4);
      bus.stall = 1'b0;
      for (int k = 7; k <= 10; k++) begin
         feed(k);
         chk_out($sformatf("d4_k%0d", k), 1'b1, mk(k-3), 1'b1, 5'd4);
      end

      // ---- Delay 5 running, then load delay 2 under stall
      load(5'd5);
      for (int k = 1; k <= 6; k++) feed(k);
      chk_out("d5_run", 1'b1, mk(2), 1'b1, 5'd5);
      bus.stall     = 1'b1;
      bus.cfg_load  = 1'b1;
      bus.cfg_delay = 5'd2;
      feed(50);
      bus.stall     = 1'b0;
      bus.cfg_load  = 1'b0;
      chk_out("load2_stalled", 1'b0, 32'h0, 1'b0, 5'd2);
      feed(20);
      chk_out("d2_first", 1'b0, 32'h0, 1'b0, 5'd2);
      feed(21);
      chk_out("d2_second", 1'b1, mk(20), 1'b1, 5'd2);

      // ---- Flush under stall keeps delay, empties pipe
      bus.stall = 1'b1;
      bus.flush = 1'b1;
      feed(60);
      bus.stall = 1'b0;
      bus.flush = 1'b0;
      chk_out("flush", 1'b0, 32'h0, 1'b0, 5'd2);
      feed(30);
      chk_out("flush_f1", 1'b0, 32'h0, 1'b0, 5'd2);
      feed(31);
      chk_out("flush_f2", 1'b1, mk(30), 1'b1, 5'd2);

      // ---- Saturating load and full depth
      load(5'd19);
      chk_out("sat_load", 1'b0, 32'h0, 1'b0, 5'd16);
      for (int k = 1; k <= 16; k++) begin
         feed(k);
         if (k == 15) chk_out("d16_k15", 1'b0, 32'h0, 1'b0, 5'd16);
      end
      chk_out("d16_k16", 1'b1, mk(1), 1'b1, 5'd16);

      // ---- Zero delay: combinational pass-through, stall ignored
      load(5'd0);
      chk("d0_primed", 64'(bus.primed), 64'(1'b1));
      chk("d0_delay",  64'(bus.cur_delay), 64'd0);
      bus.in_valid = 1'b1;
      bus.in_data  = mk(77);
      #1;
      chk("d0_pass_data",  64'(bus.out_data),  64'(mk(77)));
      chk("d0_pass_valid", 64'(bus.out_valid), 64'd1);
      bus.stall    = 1'b1;
      bus.in_valid = 1'b0;
      bus.in_data  = mk(78);
      #1;
      chk("d0_stall_data",  64'(bus.out_data),  64'(mk(78)));
      chk("d0_stall_valid", 64'(bus.out_valid), 64'd0);
      bus.stall = 1'b0;
      tick();

      // ---- Asynchronous reset mid-stream
      load(5'd4);
      for (int k = 1; k <= 6; k++) feed(k);
      chk_out("pre_clr", 1'b1, mk(3), 1'b1, 5'd4);
      #2;
      clr_n = 1'b0;
      #1;
      chk_out("clr_async", 1'b0, 32'h0, 1'b0, 5'd3);
      bus.in_valid = 1'b1;
      bus.in_data  = mk(9);
      tick();
      #2;
      clr_n = 1'b1;
      #1;
      chk_out("clr_release", 1'b0, 32'h0, 1'b0, 5'd3);
      feed(40);
      chk_out("clr_f1", 1'b0, 32'h0, 1'b0, 5'd3);
      feed(41);
      chk_out("clr_f2", 1'b0, 32'h0, 1'b0, 5'd3);
      feed(42);
      chk_out("clr_f3", 1'b1, mk(40), 1'b1, 5'd3);

      $display("%0d/%0d checks passed", n_total - n_fail, n_total);
      $finish;
   end
endmodule
`default_nettype wire
